piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in serial-out stage that feeds the serial shift-register chain with a bit stream.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clk, LSB first.
//  Emits frame-marker strobes alongside each bit.
//  A one-entry hold buffer lets the next word queue while the current one shifts out.
//  With this buffer, back-to-back words serialize with no idle cycle between frames.
// PARAMETERS
//  WIDTH      4  data word width; also the number of data bits per frame (>=2)
//  LSB_FIRST  1  1: bit 0 is shifted out first; 0: bit WIDTH-1 is shifted out first
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      reset: synchronous, active-high
//  in_data    in   WIDTH  parallel word
//  in_valid   in   1      in_data valid
//  in_ready   out  1      word accepted on an edge where in_valid && in_ready
//  ser_out    out  1      serial data bit (registered)
//  ser_valid  out  1      ser_out carries a frame bit this cycle
//  ser_first  out  1      first bit of the frame
//  ser_last   out  1      final bit of the frame
//  busy       out  1      shifter or hold buffer is occupied
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; hold buffer empty; FSM=IDLE.
//   - Reset mid-frame discards the frame in flight and any held word.
//   - No partial frame resumes after reset.
//  Hold buffer: hold_full is set on accept; it is cleared when its word loads into the shifter.
//   - If a load and an accept happen on the same edge, hold_full stays 1 with the new word.
//  in_ready = !hold_full || load_now (combinational; no bubble under continuous traffic).
//   - load_now = hold_full && (state==IDLE || bit_cnt==last index).
//  FSM (ser_state_t):
//   - IDLE: ser_valid=0, ser_out=0. If hold_full, load the shifter and go to SHIFT.
//   - SHIFT: drive one bit per cycle; bit_cnt runs 0..WIDTH-1.
//     - On the last data bit, go to PARITY (macro defined).
//     - Otherwise, if hold_full, load the next word and stay in SHIFT (bit_cnt=0).
//     - Otherwise go to IDLE.
//   - PARITY: one cycle of the parity bit, then the same load/IDLE decision as the SHIFT last bit.
//  Latency: word accepted at edge N is in hold after N. It loads at edge N+1 if the shifter is free.
//   - Its first bit appears on ser_out during the cycle after edge N+1.
//  ser_first=1 only with bit_cnt==0; ser_last=1 only on the final frame bit.
//  Both strobes are 0 whenever ser_valid=0.
//  Downstream has no backpressure: once loaded, a frame always completes in consecutive cycles.
//  bit_cnt width: $clog2(WIDTH+1); it never exceeds the frame length - 1.
//  busy = (state!=IDLE) || hold_full.
// CONFIGURATION
//  PISO_PARITY_EN defined:
//   - Frame = WIDTH data bits + 1 even-parity bit (^word) sent last.
//   - ser_last is asserted on the parity bit, not on the last data bit.
//   - Frame length = WIDTH+1 cycles.
//  PISO_PARITY_EN undefined:
//   - No PARITY state; frame = WIDTH cycles.
//   - ser_last is asserted on data bit WIDTH-1 (in transmit order).
// STRUCTURE
//  Package piso_pkg:
//   - ser_state_t enum {IDLE, SHIFT, PARITY}.
//   - localparam FRAME_LEN function of WIDTH and PISO_PARITY_EN.
//  Sub-module piso_hold_buf:
//   - One-entry valid/ready buffer with in_data/in_valid/in_ready on one side.
//   - Exposes hold_data/hold_full/load_now on the other side.
//   - The top level holds the FSM, shifter and bit counter.
// TESTING (WIDTH=4, LSB_FIRST=1)
//  1. Reset held 2 cycles, in_valid=0.
//     -> ser_valid=0, ser_out=0, in_ready=1, busy=0 throughout.
//  2. Single 4'b1101.
//     -> ser_out 1,0,1,1 on 4 consecutive ser_valid cycles.
//     -> ser_first on bit 1; ser_last on bit 4; then IDLE.
//  3. 4'b1101 then 4'b0110, in_valid held.
//     -> 8 contiguous ser_valid cycles: 1,0,1,1,0,1,1,0.
//     -> ser_first on cycles 1 and 5.
//  4. Three words offered back-to-back.
//     -> Word 2 is held; in_ready=0 until the last bit of word 1.
//     -> Word 3 is accepted on that edge; no gap between frames.
//  5. rst asserted after 2 bits of 4'b1011.
//     -> Next cycle ser_valid=0; held word dropped.
//     -> A new 4'b0001 after reset serializes 1,0,0,0.
//  6. PISO_PARITY_EN, 4'b1101.
//     -> 5 bits 1,0,1,1,1; ser_last on the parity bit.
//     -> 4'b0011 ends with parity 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the parallel-in serial-out stage.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit to every frame.
// Contents: ser_state_t, PARITY_EN, frame_len(), FRAME_LEN for the default width.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Frame length in cycles: data bits plus the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width);
    return width + (PARITY_EN ? 32'd1 : 32'd0);
  endfunction

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned FRAME_LEN = frame_len(DEF_WIDTH);

endpackage

// File: rtl/piso_serializer_if.sv
// Bus bundle for piso_serializer: parallel word handshake plus serial output and strobes.
// Ports: in_data/in_valid (to DUT), in_ready (from DUT),
//        ser_out/ser_valid/ser_first/ser_last/busy (from DUT).
// modport master: word producer / serial consumer side; modport slave: the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_first,
    input  ser_last,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output ser_first,
    output ser_last,
    output busy
  );

endinterface

// File: rtl/piso_hold_buf.sv
// One-entry hold buffer in front of the shifter.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready upstream handshake;
//        load_req (shifter can take a word this edge); hold_data/hold_full/load_now to shifter.
// in_ready is combinational so a word can enter on the same edge the held one leaves.
module piso_hold_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load_req,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full,
  output logic             load_now
);

  logic accept;

  assign load_now = hold_full && load_req;
  assign in_ready = !hold_full || load_now;
  assign accept   = in_valid && in_ready;

  // Accept wins over load: a simultaneous load+accept leaves the buffer full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: one bit per clk with first/last frame strobes.
// Ports: clk, rst (sync, active-high), bus (piso_serializer_if.slave):
//        in_data/in_valid/in_ready word handshake, ser_out/ser_valid/ser_first/ser_last
//        registered serial outputs, busy = shifter or hold buffer occupied.
// Parameters: WIDTH (>=2) data bits per frame; LSB_FIRST selects transmit order.
// Build option: define PISO_PARITY_EN to append an even-parity bit (ser_last moves to it).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int unsigned FRAME_LEN_W = frame_len(WIDTH);
  localparam int unsigned CNT_W       = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN_W - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             load_now;
  logic             load_req;
  logic             frame_done;

  // Bit that goes on the wire first for a given (possibly already advanced) word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // Drop the bit just transmitted so the next one sits at the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // Shifter is free when idle or when the final frame bit is on the wire.
  // cnt_q is cleared on entry to IDLE, so it only matches LAST_IDX inside a frame.
  assign load_req = (state_q == IDLE) || (cnt_q == LAST_IDX);

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .load_req  (load_req),
    .hold_data (hold_data),
    .hold_full (hold_full),
    .load_now  (load_now)
  );

  // State register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs describe the bit shown after the coming edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    frame_done  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        frame_done = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST_DATA) begin
`ifdef PISO_PARITY_EN
          state_d     = PARITY;
          cnt_d       = cnt_q + CNT_W'(1);
          ser_out_d   = parity_q;
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b1;
`else
          frame_done  = 1'b1;
`endif
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          ser_out_d   = first_bit(shreg_q);
          shreg_d     = advance(shreg_q);
          ser_valid_d = 1'b1;
          ser_last_d  = ((cnt_q + CNT_W'(1)) == LAST_IDX);
        end
      end
      PARITY: begin
        frame_done = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Shared end-of-frame decision: chain straight into the held word or fall idle.
    if (frame_done) begin
      if (load_now) begin
        state_d     = SHIFT;
        cnt_d       = '0;
        ser_out_d   = first_bit(hold_data);
        shreg_d     = advance(hold_data);
        ser_valid_d = 1'b1;
        ser_first_d = 1'b1;
`ifdef PISO_PARITY_EN
        parity_d    = ^hold_data;
`endif
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = (state_q != IDLE) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer (WIDTH=4, LSB_FIRST=1); works with or without PISO_PARITY_EN.
// Reference model: each accepted word becomes a frame whose start cycle is
// max(accept_edge+1, previous_frame_end+1); outputs, busy and in_ready follow from that timeline.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int FL = PARITY_EN ? int'(WIDTH) + 1 : int'(WIDTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int               start;
    logic [WIDTH-1:0] word;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_end = -1;
  int last_n = 0;
  int last_start = 0;
  bit have = 1'b0;
  bit acc_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame bit idx of word w: data LSB first, then even parity (odd count of ones -> 1).
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int idx);
    int ones;
    ones = 0;
    if (idx < int'(WIDTH)) return w[idx];
    for (int i = 0; i < int'(WIDTH); i++) ones += int'(w[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d act=%b exp=%b", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the model timeline, then advance the model.
  always @(negedge clk) begin
    int t, idx, n, s;
    logic ev, eb, ef, el, busy_exp, ready_exp;
    t = cyc;
    if (t >= 1) begin
      ev = 1'b0; eb = 1'b0; ef = 1'b0; el = 1'b0; idx = 0;
      if (sb.size() > 0 && sb[0].start <= t) begin
        ev  = 1'b1;
        idx = t - sb[0].start;
        eb  = exp_bit(sb[0].word, idx);
        ef  = (idx == 0);
        el  = (idx == FL - 1);
      end
      busy_exp  = ev || (have && last_n <= t && t < last_start);
      ready_exp = !(have && last_n <= t && last_start > t + 1);

      chk("ser_valid", bus.ser_valid, ev);
      chk("ser_out",   bus.ser_out,   eb);
      chk("ser_first", bus.ser_first, ef);
      chk("ser_last",  bus.ser_last,  el);
      chk("busy",      bus.busy,      busy_exp);
      chk("in_ready",  bus.in_ready,  ready_exp);

      if (ev && idx == FL - 1) void'(sb.pop_front());

      acc_flag = 1'b0;
      if (rst) begin
        sb.delete();
        have     = 1'b0;
        prev_end = -1;
      end else if (bus.in_valid && ready_exp) begin
        n = t + 1;
        s = (n + 1 > prev_end + 1) ? n + 1 : prev_end + 1;
        sb.push_back('{s, bus.in_data});
        prev_end   = s + FL - 1;
        have       = 1'b1;
        last_n     = n;
        last_start = s;
        acc_flag   = 1'b1;
      end
    end
  end

  // Offer one word and return right after the edge that accepts it (in_valid stays high).
  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!acc_flag && n < 50);
    chk("accepted", acc_flag, 1'b1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size() == 0, 1'b1);
    idle(2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle(2);

    // Single word.
    send(4'b1101);
    drain();

    // Two words with in_valid held: contiguous frames.
    send(4'b1101);
    send(4'b0110);
    drain();

    // Three words back-to-back: second waits in hold, third enters on the first frame's last bit.
    send(4'b1001);
    send(4'b0111);
    send(4'b1010);
    drain();

    // Parity-distinguishing words.
    send(4'b0011);
    send(4'b1110);
    drain();

    // Reset after two bits with a word held; then a fresh frame.
    send(4'b1011);
    send(4'b0110);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    do_reset(1);
    idle(1);
    send(4'b0001);
    drain();

    // Randomized traffic with occasional gaps and resets.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        send(WIDTH'($urandom));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

endmodule
